// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package wb_arb_pkg;
  localparam int REG_W        = 5;
  localparam int DATA_W       = 32;
  localparam int DEPTH_DEF    = 2;
  localparam int MAX_WAIT_DEF = 4;
  localparam int WAIT_W       = 4;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  regno;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // True when a live entry targets the given register.
  function automatic logic reg_match(input wb_entry_t e, input logic [REG_W-1:0] r);
    return e.valid && (e.regno == r);
  endfunction
endpackage

// File: rtl/wb_arb_fifo.sv
// Circular holding buffer for MUL/DIV results with per-entry kill by destination register.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  input  logic             kill_en,
  input  logic [REG_W-1:0] kill_reg,
  output wb_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic             any_valid
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == {CW{1'b0}});
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // Free slots always carry valid=0, so OR-ing every slot reflects live entries only.
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_valid = any_valid | mem_q[i].valid;
    end
  end

  // Next-state: kill stored matches, retire the popped slot, then write the pushed entry.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i].valid = mem_q[i].valid & ~(kill_en & reg_match(mem_q[i], kill_reg));
    end
    mem_d[rd_ptr_q].valid = mem_d[rd_ptr_q].valid & ~pop_ok;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Buffer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {($bits(wb_entry_t)){1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the pipeline and buffered MUL/DIV results.
// Optional WB_ARB_STATS_EN adds a saturating conflict_count output.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_RegWrite,
  input  logic [REG_W-1:0]  wb_WriteRegister,
  input  logic [DATA_W-1:0] wb_WriteData,
  input  logic              md_valid,
  input  logic [REG_W-1:0]  md_WriteRegister,
  input  logic [DATA_W-1:0] md_Result,
  output logic              md_ready,
  output logic              RegWrite_Out,
  output logic [REG_W-1:0]  WriteRegister_Out,
  output logic [DATA_W-1:0] WriteData_Out,
  output logic              Stall_Out
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_count
`endif
);
  wb_entry_t         head;
  wb_entry_t         push_entry;
  logic              fifo_full, fifo_empty, fifo_pop, fifo_any_valid;
  logic              kill_en, head_grant, pipe_grant;
  logic              regwrite_q, regwrite_d;
  logic [REG_W-1:0]  wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  assign push_entry        = '{valid: 1'b1, regno: md_WriteRegister, data: md_Result};
  assign md_ready          = !fifo_full;
  assign Stall_Out         = (wait_q == WAIT_W'(MAX_WAIT));
  assign RegWrite_Out      = regwrite_q;
  assign WriteRegister_Out = wreg_q;
  assign WriteData_Out     = wdata_q;

  wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (md_valid),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .kill_en    (kill_en),
    .kill_reg   (wb_WriteRegister),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .any_valid  (fifo_any_valid)
  );

  // Grant priority: forced drain, then pipeline, then buffered head; killed heads drop silently.
  always_comb begin
    head_grant = 1'b0;
    pipe_grant = 1'b0;
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    if (Stall_Out) begin
      head_grant = 1'b1;
    end else if (wb_RegWrite) begin
      pipe_grant = 1'b1;
    end else if (!fifo_empty) begin
      head_grant = 1'b1;
    end else begin
      head_grant = 1'b0;
    end
    if (head_grant && head.valid) begin
      regwrite_d = (head.regno != {REG_W{1'b0}});
      wreg_d     = head.regno;
      wdata_d    = head.data;
    end else if (pipe_grant) begin
      regwrite_d = (wb_WriteRegister != {REG_W{1'b0}});
      wreg_d     = wb_WriteRegister;
      wdata_d    = wb_WriteData;
    end else begin
      regwrite_d = 1'b0;
    end
    kill_en  = pipe_grant && (wb_WriteRegister != {REG_W{1'b0}});
    fifo_pop = head_grant || (!fifo_empty && !head.valid);
    wait_d   = (fifo_empty || fifo_pop) ? {WAIT_W{1'b0}} : (wait_q + WAIT_W'(1));
  end

  // Write-port output and starvation counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      wreg_q     <= {REG_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      wait_q     <= {WAIT_W{1'b0}};
    end else begin
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      wait_q     <= wait_d;
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [15:0] conflict_q, conflict_d;

  assign conflict_count = conflict_q;

  // Count cycles where the pipeline writes while a live MUL/DIV result is parked.
  always_comb begin
    if (wb_RegWrite && fifo_any_valid && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end else begin
      conflict_d = conflict_q;
    end
  end

  // Conflict statistics register.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_q <= 16'd0;
    end else begin
      conflict_q <= conflict_d;
    end
  end
`else
  logic unused_any_valid;
  assign unused_any_valid = fifo_any_valid;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts every register-file write and the handshake outputs.
module tb_wb_port_arbiter;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_RegWrite;
  logic [4:0]  wb_WriteRegister;
  logic [31:0] wb_WriteData;
  logic        md_valid;
  logic [4:0]  md_WriteRegister;
  logic [31:0] md_Result;
  logic        md_ready;
  logic        RegWrite_Out;
  logic [4:0]  WriteRegister_Out;
  logic [31:0] WriteData_Out;
  logic        Stall_Out;
`ifdef WB_ARB_STATS_EN
  logic [15:0] conflict_count;
`endif

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk               (clk),
    .reset             (reset),
    .wb_RegWrite       (wb_RegWrite),
    .wb_WriteRegister  (wb_WriteRegister),
    .wb_WriteData      (wb_WriteData),
    .md_valid          (md_valid),
    .md_WriteRegister  (md_WriteRegister),
    .md_Result         (md_Result),
    .md_ready          (md_ready),
    .RegWrite_Out      (RegWrite_Out),
    .WriteRegister_Out (WriteRegister_Out),
    .WriteData_Out     (WriteData_Out),
    .Stall_Out         (Stall_Out)
`ifdef WB_ARB_STATS_EN
    ,
    .conflict_count    (conflict_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { bit v; int r; logic [31:0] d; } ment_t;
  typedef struct { int cyc; int r; logic [31:0] d; } exp_t;

  ment_t mq[$];
  exp_t  sb[$];
  int    mw = 0;
  int    cyc = 0;
  int    m_cc = 0;
  bit    armed = 0;
  int    n_checks = 0;
  int    n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Reference model: applies the arbitration rules to a plain queue at each edge.
  ment_t h;
  bit    pre_empty, popped, accept, anyv;
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      mq.delete(); sb.delete(); mw = 0; m_cc = 0; armed = 1;
    end else begin
      pre_empty = (mq.size() == 0);
      accept    = md_valid && (mq.size() < DEPTH);
      popped    = 0;
      anyv      = 0;
      foreach (mq[i]) if (mq[i].v) anyv = 1;
      if (wb_RegWrite && anyv && m_cc < 65535) m_cc++;
      if (mw == MAX_WAIT || (!wb_RegWrite && !pre_empty)) begin
        h = mq.pop_front(); popped = 1;
        if (h.v && h.r != 0) sb.push_back('{cyc, h.r, h.d});
      end else if (wb_RegWrite) begin
        if (!pre_empty && !mq[0].v) begin h = mq.pop_front(); popped = 1; end
        if (wb_WriteRegister != 0) begin
          sb.push_back('{cyc, int'(wb_WriteRegister), wb_WriteData});
          foreach (mq[i]) if (mq[i].r == int'(wb_WriteRegister)) mq[i].v = 0;
        end
      end
      mw = (pre_empty || popped) ? 0 : mw + 1;
      if (accept) mq.push_back('{1'b1, int'(md_WriteRegister), md_Result});
    end
  end

  // Monitor: compares handshake outputs and pops the scoreboard on every write.
  exp_t e;
  always @(negedge clk) begin
    if (armed) begin
      chk("md_ready", {31'd0, md_ready}, {31'd0, (mq.size() < DEPTH)});
      chk("stall", {31'd0, Stall_Out}, {31'd0, (mw == MAX_WAIT)});
`ifdef WB_ARB_STATS_EN
      chk("conflict_count", {16'd0, conflict_count}, m_cc);
`endif
      if (RegWrite_Out) begin
        if (sb.size() == 0) chk("unexpected_write", {31'd0, RegWrite_Out}, 32'd0);
        else begin
          e = sb.pop_front();
          chk("write_cycle", cyc, e.cyc);
          chk("write_reg", {27'd0, WriteRegister_Out}, e.r);
          chk("write_data", WriteData_Out, e.d);
        end
      end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
        chk("missing_write", {31'd0, RegWrite_Out}, 32'd1);
        e = sb.pop_front();
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit we, input int wr, input logic [31:0] wd,
                       input bit mv, input int mr, input logic [31:0] md);
    wb_RegWrite = we; wb_WriteRegister = 5'(wr); wb_WriteData = wd;
    md_valid = mv; md_WriteRegister = 5'(mr); md_Result = md;
  endtask

  initial begin
    reset = 1'b1;
    drive(1, 3, 32'hDEAD, 1, 7, 32'hBEEF);
    step(); step();
    chk("reset_regwrite", {31'd0, RegWrite_Out}, 32'd0);
    chk("reset_stall", {31'd0, Stall_Out}, 32'd0);
    chk("reset_md_ready", {31'd0, md_ready}, 32'd1);
    chk("reset_wdata", WriteData_Out, 32'd0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0); step();

    // Idle pipeline, single buffered result.
    drive(0, 0, 0, 1, 8, 32'h1234); step();
    drive(0, 0, 0, 0, 0, 0); step();
    chk("idle_drain_we", {31'd0, RegWrite_Out}, 32'd1);
    chk("idle_drain_reg", {27'd0, WriteRegister_Out}, 32'd8);
    chk("idle_drain_data", WriteData_Out, 32'h1234);
    step();

    // Busy pipeline forces a one-cycle stall after MAX_WAIT cycles.
    drive(1, 3, 32'h33, 1, 9, 32'h99); step();
    drive(1, 3, 32'h33, 0, 0, 0);
    for (int k = 0; k <= MAX_WAIT; k++) begin
      if (k > 0) step();
      chk("starve_stall", {31'd0, Stall_Out}, {31'd0, (k == MAX_WAIT)});
    end
    step();
    chk("starve_drain_reg", {27'd0, WriteRegister_Out}, 32'd9);
    step();
    chk("starve_resume_reg", {27'd0, WriteRegister_Out}, 32'd3);
    drive(0, 0, 0, 0, 0, 0); step(); step();

    // WAW kill of a parked r5 result.
    drive(1, 1, 32'h11, 1, 5, 32'h5555); step();
    drive(1, 5, 32'h5A5A, 0, 0, 0); step();
    chk("kill_pipe_reg", {27'd0, WriteRegister_Out}, 32'd5);
    drive(0, 0, 0, 0, 0, 0); step(); step(); step();
    chk("kill_ready", {31'd0, md_ready}, 32'd1);

    // Fill the buffer while the pipeline is busy, then hold a third result off.
    drive(1, 2, 32'h22, 1, 10, 32'hA0); step();
    drive(1, 2, 32'h22, 1, 11, 32'hB0); step();
    chk("full_ready", {31'd0, md_ready}, 32'd0);
    drive(1, 2, 32'h22, 1, 12, 32'hC0);
    begin
      int budget = 20;
      while (!md_ready && budget > 0) begin step(); budget--; end
      chk("full_wait_budget", {31'd0, (budget > 0)}, 32'd1);
    end
    step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (6) step();

    // Register $0 result is consumed without a write.
    drive(0, 0, 0, 1, 0, 32'hFFFF); step();
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("r0_no_write", {31'd0, RegWrite_Out}, 32'd0);
    end

    // Randomised traffic with occasional mid-run reset.
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 99) < 55, $urandom_range(0, 7), $urandom,
            $urandom_range(0, 99) < 45, $urandom_range(0, 7), $urandom);
      step();
    end
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (10) step();
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
